// File: rtl/nettlp_cmd_arb.sv
// Round-robin arbiter that feeds NetTLP commands from two requester FIFOs into the
// command core one at a time and routes register-read responses back to the requester.
package nettlp_cmd_pkg;
   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] dwaddr;
      logic [31:0] data;
   } FIFO_NETTLP_CMD_T;

   localparam logic [7:0]  NETTLP_OPC_REG_RD = 8'h01;
   localparam logic [7:0]  NETTLP_OPC_REG_WR = 8'h02;
   localparam logic [15:0] ADAPTER_REG_MAGIC = 16'h0000;
endpackage

module nettlp_cmd_arb
   import nettlp_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   output logic             fifo_req0_rd_en,
   input  logic             fifo_req0_empty,
   input  FIFO_NETTLP_CMD_T fifo_req0_dout,
   output logic             fifo_req1_rd_en,
   input  logic             fifo_req1_empty,
   input  FIFO_NETTLP_CMD_T fifo_req1_dout,
   output logic             fifo_cmd_i_wr_en,
   input  logic             fifo_cmd_i_full,
   output FIFO_NETTLP_CMD_T fifo_cmd_i_din,
   output logic             fifo_cmd_o_rd_en,
   input  logic             fifo_cmd_o_empty,
   input  FIFO_NETTLP_CMD_T fifo_cmd_o_dout,
   output logic             fifo_rsp0_wr_en,
   input  logic             fifo_rsp0_full,
   output FIFO_NETTLP_CMD_T fifo_rsp0_din,
   output logic             fifo_rsp1_wr_en,
   input  logic             fifo_rsp1_full,
   output FIFO_NETTLP_CMD_T fifo_rsp1_din,
   output logic [15:0]      stat_timeout_cnt,
   output logic [15:0]      stat_stray_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RETURN} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t           state_q, state_d;
   FIFO_NETTLP_CMD_T cmd_q, cmd_d, rsp_q, rsp_d;
   logic             grant_q, grant_d, last_q, last_d;
   logic [15:0]      tmo_q, tmo_d;
   logic             req0_rd_en_q, req0_rd_en_d, req1_rd_en_q, req1_rd_en_d;
   logic             cmd_i_wr_en_q, cmd_i_wr_en_d, cmd_o_rd_en_q, cmd_o_rd_en_d;
   FIFO_NETTLP_CMD_T cmd_i_din_q, cmd_i_din_d;
   logic             rsp0_wr_en_q, rsp0_wr_en_d, rsp1_wr_en_q, rsp1_wr_en_d;
   FIFO_NETTLP_CMD_T rsp0_din_q, rsp0_din_d, rsp1_din_q, rsp1_din_d;
   logic [15:0]      stat_tmo_q, stat_tmo_d, stat_stray_q, stat_stray_d;
   logic             pick;
   logic             rsp_blocked;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign rsp_blocked = grant_q ? fifo_rsp1_full : fifo_rsp0_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cmd_q         <= '0;
         rsp_q         <= '0;
         grant_q       <= 1'b0;
         last_q        <= 1'b1;
         tmo_q         <= '0;
         req0_rd_en_q  <= 1'b0;
         req1_rd_en_q  <= 1'b0;
         cmd_i_wr_en_q <= 1'b0;
         cmd_i_din_q   <= '0;
         cmd_o_rd_en_q <= 1'b0;
         rsp0_wr_en_q  <= 1'b0;
         rsp0_din_q    <= '0;
         rsp1_wr_en_q  <= 1'b0;
         rsp1_din_q    <= '0;
         stat_tmo_q    <= '0;
         stat_stray_q  <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         rsp_q         <= rsp_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         tmo_q         <= tmo_d;
         req0_rd_en_q  <= req0_rd_en_d;
         req1_rd_en_q  <= req1_rd_en_d;
         cmd_i_wr_en_q <= cmd_i_wr_en_d;
         cmd_i_din_q   <= cmd_i_din_d;
         cmd_o_rd_en_q <= cmd_o_rd_en_d;
         rsp0_wr_en_q  <= rsp0_wr_en_d;
         rsp0_din_q    <= rsp0_din_d;
         rsp1_wr_en_q  <= rsp1_wr_en_d;
         rsp1_din_q    <= rsp1_din_d;
         stat_tmo_q    <= stat_tmo_d;
         stat_stray_q  <= stat_stray_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (!fifo_req0_empty || !fifo_req1_empty) state_d = S_ISSUE;
         S_ISSUE:    if (!fifo_cmd_i_full)
                        state_d = (cmd_q.opcode == NETTLP_OPC_REG_RD) ? S_WAIT_RSP : S_IDLE;
         S_WAIT_RSP: if (!fifo_cmd_o_empty)   state_d = S_RETURN;
                     else if (tmo_q == TMO_LAST) state_d = S_IDLE;
         S_RETURN:   if (!rsp_blocked) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_d         = cmd_q;
      rsp_d         = rsp_q;
      grant_d       = grant_q;
      last_d        = last_q;
      tmo_d         = tmo_q;
      req0_rd_en_d  = 1'b0;
      req1_rd_en_d  = 1'b0;
      cmd_i_wr_en_d = 1'b0;
      cmd_i_din_d   = cmd_i_din_q;
      cmd_o_rd_en_d = 1'b0;
      rsp0_wr_en_d  = 1'b0;
      rsp0_din_d    = rsp0_din_q;
      rsp1_wr_en_d  = 1'b0;
      rsp1_din_d    = rsp1_din_q;
      stat_tmo_d    = stat_tmo_q;
      stat_stray_d  = stat_stray_q;
      pick          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_req0_empty || !fifo_req1_empty) begin
               pick         = (!fifo_req0_empty && !fifo_req1_empty) ? ~last_q : fifo_req0_empty;
               req0_rd_en_d = ~pick;
               req1_rd_en_d = pick;
               cmd_d        = pick ? fifo_req1_dout : fifo_req0_dout;
               grant_d      = pick;
               last_d       = pick;
            end
            // The pop pulse lands one cycle late, so skip a head we are already popping.
            if (!fifo_cmd_o_empty && !cmd_o_rd_en_q) begin
               cmd_o_rd_en_d = 1'b1;
               stat_stray_d  = sat_inc(stat_stray_q);
            end
         end
         S_ISSUE: begin
            if (!fifo_cmd_i_full) begin
               cmd_i_wr_en_d = 1'b1;
               cmd_i_din_d   = cmd_q;
               tmo_d         = '0;
            end
         end
         S_WAIT_RSP: begin
            if (!fifo_cmd_o_empty) begin
               cmd_o_rd_en_d = 1'b1;
               rsp_d         = fifo_cmd_o_dout;
            end else if (tmo_q == TMO_LAST) begin
               stat_tmo_d = sat_inc(stat_tmo_q);
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RETURN: begin
            if (!rsp_blocked) begin
               if (grant_q) begin
                  rsp1_wr_en_d = 1'b1;
                  rsp1_din_d   = rsp_q;
               end else begin
                  rsp0_wr_en_d = 1'b1;
                  rsp0_din_d   = rsp_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign fifo_req0_rd_en  = req0_rd_en_q;
   assign fifo_req1_rd_en  = req1_rd_en_q;
   assign fifo_cmd_i_wr_en = cmd_i_wr_en_q;
   assign fifo_cmd_i_din   = cmd_i_din_q;
   assign fifo_cmd_o_rd_en = cmd_o_rd_en_q;
   assign fifo_rsp0_wr_en  = rsp0_wr_en_q;
   assign fifo_rsp0_din    = rsp0_din_q;
   assign fifo_rsp1_wr_en  = rsp1_wr_en_q;
   assign fifo_rsp1_din    = rsp1_din_q;
   assign stat_timeout_cnt = stat_tmo_q;
   assign stat_stray_cnt   = stat_stray_q;

endmodule

// File: doc/nettlp_cmd_arb.md
NETTLP_CMD_ARB -- requirements
Module: nettlp_cmd_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: cycles to wait for a register-read response before abandoning it (legal range 2..65535).
REQ-002 Port clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port fifo_req0_rd_en  output  1  pop pulse to requester-0 command FIFO (UDP path).
REQ-005 Port fifo_req0_empty  input  1  requester-0 FIFO empty.
REQ-006 Port fifo_req0_dout  input  FIFO_NETTLP_CMD_T  requester-0 head command (first-word-fall-through, valid while empty=0).
REQ-007 Ports fifo_req1_rd_en / fifo_req1_empty / fifo_req1_dout SHALL mirror REQ-004..006 for requester 1 (local BAR path).
REQ-008 Port fifo_cmd_i_wr_en  output  1  push pulse into the command-core input FIFO.
REQ-009 Port fifo_cmd_i_full  input  1  command-core input FIFO full.
REQ-010 Port fifo_cmd_i_din  output  FIFO_NETTLP_CMD_T  command forwarded to the core.
REQ-011 Port fifo_cmd_o_rd_en  output  1  pop pulse to the core response FIFO.
REQ-012 Port fifo_cmd_o_empty  input  1  core response FIFO empty.
REQ-013 Port fifo_cmd_o_dout  input  FIFO_NETTLP_CMD_T  core response head (FWFT).
REQ-014 Ports fifo_rsp0_wr_en (out 1), fifo_rsp0_full (in 1), fifo_rsp0_din (out FIFO_NETTLP_CMD_T) SHALL carry responses to requester 0; fifo_rsp1_* likewise to requester 1.
REQ-015 Port stat_timeout_cnt  output  16  saturating count of abandoned reads.
REQ-016 Port stat_stray_cnt  output  16  saturating count of discarded unsolicited responses.

Function
REQ-017 All outputs SHALL be registered; every rd_en/wr_en SHALL be a single-cycle pulse, 0 in any cycle not explicitly driving it.
REQ-018 States: IDLE, ISSUE, WAIT_RSP, RETURN; at most one command is in flight.
REQ-019 IDLE: if at least one requester FIFO is non-empty, select one, pulse its rd_en, latch its dout and the grant index, go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: with both non-empty, grant the requester not granted last; with one non-empty, grant it regardless.
REQ-021 ISSUE: while fifo_cmd_i_full=1 hold; otherwise pulse fifo_cmd_i_wr_en with the latched command, then go to WAIT_RSP (timeout counter cleared) if opcode==NETTLP_OPC_REG_RD, else IDLE.
REQ-022 WAIT_RSP: if fifo_cmd_o_empty=0, pulse fifo_cmd_o_rd_en, latch fifo_cmd_o_dout, go to RETURN; else increment the counter, and on reaching TIMEOUT-1 go to IDLE and increment stat_timeout_cnt.
REQ-023 RETURN: while the granted requester's rsp FIFO is full hold; otherwise pulse its rsp wr_en with the latched response (unmodified), go to IDLE.
REQ-024 In IDLE, a non-empty core response FIFO SHALL be popped and discarded (stat_stray_cnt++) in the same cycle, taking priority over no other action (request pop may coincide).
REQ-025 Response arriving in the same cycle the timeout fires SHALL be accepted (response wins).
REQ-026 Statistics counters SHALL saturate at 16'hFFFF.
REQ-027 Minimum write throughput: IDLE->ISSUE->IDLE, one command per 2 cycles.

Reset
REQ-028 On rst: state IDLE, all rd_en/wr_en 0, *_din all-zero, counters 0, timeout counter 0, last-grant = requester 1 (requester 0 wins first tie).
REQ-029 rst mid-operation SHALL drop the in-flight command/response without any further pulse; no FIFO is popped or pushed in the reset cycle.

Verification
REQ-030 Read ADAPTER_REG_MAGIC from req0, core model replies data 32'h67452301 after 3 cycles -> exactly one fifo_rsp0_wr_en with that data; rsp1 untouched.
REQ-031 Both requesters hold 4 REG_WR each, queues continuously non-empty -> fifo_cmd_i_din grant order 0,1,0,1,0,1,0,1; 8 wr_en pulses.
REQ-032 REG_RD with unmapped dwaddr, core never replies, TIMEOUT=16 -> return to IDLE 16 cycles after entering WAIT_RSP, stat_timeout_cnt=1, no rsp pulse.
REQ-033 fifo_cmd_i_full held 10 cycles during ISSUE, then fifo_rsp1_full held 5 cycles during RETURN -> no wr_en while full; single pulse each after release.
REQ-034 Unsolicited response present in IDLE -> popped same cycle, stat_stray_cnt=1, no rsp pulse.
REQ-035 rst asserted one cycle in WAIT_RSP -> outputs at reset values next cycle; late response subsequently counted as stray.
